// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 joystick responder.
// The button layout constant gives the FEDCBAUDLR order used in joy1/joy2 bits [9:0].
package joy_db15_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int JOY_WORD_W = 16;
  localparam int JOY_BTN_W  = 10;
  localparam string JOY_BTN_LAYOUT = "FEDCBAUDLR";

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_D     = 7;
  localparam int BTN_E     = 8;
  localparam int BTN_F     = 9;

  // The wire is active-low, so a pressed button is sent as 0.
  function automatic logic [JOY_WORD_W-1:0] wire_word(input logic [JOY_WORD_W-1:0] btns);
    return ~btns;
  endfunction

endpackage

// File: rtl/joy_db15_responder_sync_edge.sv
// sync_edge: 2-FF synchronizer plus a third stage for rise detection.
// All stages reset to 1 so an idle-high line produces no edge out of reset.
module sync_edge
  import joy_db15_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sh <= '1;
    else          sh <= {sh[1:0], din};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];

endmodule

// File: rtl/joy_db15_responder.sv
// DB15 joystick adapter emulator: parallel-load / serial-out chain clocked by the reader.
// Optional link watchdog is compiled in with JOY_DB15_RSP_WATCHDOG_EN.
module joy_db15_responder
  import joy_db15_pkg::*;
#(
  parameter int PLAYERS        = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JOY_WORD_W-1:0] joy1,
  input  logic [JOY_WORD_W-1:0] joy2,
  input  logic                  JOY_CLK,
  input  logic                  JOY_LOAD,
  output logic                  JOY_DATA,
  output logic                  frame_done,
  output logic [5:0]            bit_cnt,
  output logic                  overrun,
  output logic                  link_idle
);

  localparam int N = JOY_WORD_W * PLAYERS;

  logic         load_lvl;
  logic         load_rise_unused;
  logic         clk_lvl_unused;
  logic         clk_rise;
  logic [N-1:0] image;
  logic [N-1:0] sr;
  state_t       state;

  sync_edge u_sync_load (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (JOY_LOAD),
    .level  (load_lvl),
    .rise   (load_rise_unused)
  );

  sync_edge u_sync_clk (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (JOY_CLK),
    .level  (clk_lvl_unused),
    .rise   (clk_rise)
  );

  generate
    if (PLAYERS == 2) begin : g_two
      assign image = {wire_word(joy1), wire_word(joy2)};
    end else begin : g_one
      wire joy2_unused = ^joy2;
      assign image = wire_word(joy1);
    end
  endgenerate

  // A low LOAD level overrides everything, including a coincident CLK rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sr         <= '1;
      bit_cnt    <= '0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_lvl) begin
        state   <= LOAD;
        sr      <= image;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: sr <= '1;
          LOAD: state <= SHIFT;
          SHIFT: begin
            if (clk_rise) begin
              sr      <= {sr[N-2:0], 1'b1};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'(N - 1)) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DONE: begin
            sr <= '1;
            if (clk_rise) begin
              overrun <= 1'b1;
              if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef JOY_DB15_RSP_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_next;

  assign wd_next = (wd_cnt == WD_W'(TIMEOUT_CYCLES)) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      link_idle <= 1'b0;
    end else if (!load_lvl) begin
      wd_cnt    <= '0;
      link_idle <= 1'b0;
    end else begin
      wd_cnt    <= wd_next;
      link_idle <= (wd_next == WD_W'(TIMEOUT_CYCLES));
    end
  end

  assign JOY_DATA = link_idle | sr[N-1];
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

  assign link_idle = 1'b0;
  assign JOY_DATA  = sr[N-1];
`endif

endmodule

// File: doc/joy_db15_responder.md
# joy_db15_responder

Device-side counterpart of the DB15 serial joystick protocol. It emulates the adapter's parallel-in/serial-out shift chain: it samples the `JOY_LOAD` and `JOY_CLK` lines driven by the core's DB15 reader and returns button state on `JOY_DATA`. It serves as a loopback target for bench and hardware self-test of the UserIO joystick path, and as a drop-in adapter emulator for a second FPGA driving a core through the user port.

## Interface
Parameters:
- `PLAYERS`, default 2: number of 16-bit player words in the chain. Legal values are 1 and 2.
- `TIMEOUT_CYCLES`, default 1_000_000: `clk` cycles without a `JOY_LOAD` assertion before `link_idle` rises. Used only when the watchdog is compiled in.

Ports:
- `clk`, in, 1: system clock, 40–50 MHz.
- `reset_n`, in, 1: asynchronous assert, active-low reset.
- `joy1`, in, 16: player 1 buttons, active-high, laid out as `FEDCBAUDLR` in bits [9:0]; bits [15:10] are spare.
- `joy2`, in, 16: player 2 buttons. Ignored when `PLAYERS`=1.
- `JOY_CLK`, in, 1: shift clock from the reader. Asynchronous to `clk`.
- `JOY_LOAD`, in, 1: active-low parallel load from the reader. Asynchronous to `clk`.
- `JOY_DATA`, out, 1: serial data, active-low (0 means pressed).
- `frame_done`, out, 1: one-cycle pulse when the last chain bit has been shifted out.
- `bit_cnt`, out, 6: number of shifts since the last load.
- `overrun`, out, 1: sticky flag, set when the reader clocks beyond the chain length; cleared by the next load.
- `link_idle`, out, 1: watchdog flag (see Configuration).

## Operation
- `JOY_CLK` and `JOY_LOAD` each pass through a 2-FF synchronizer. A third register provides edge detection.
- Chain length is N = 16·`PLAYERS`. The shift register `sr[N-1:0]` holds inverted button data.
- Load image: `{~joy1, ~joy2}` for 2 players, `~joy1` for 1 player. `joy1[15]` sits at the MSB.
- `JOY_DATA` = `sr[N-1]`.
- State machine:
  - IDLE: entered at reset. `sr` is all ones and `JOY_DATA`=1. On synced LOAD low, go to LOAD.
  - LOAD: while synced LOAD is low, reload `sr` from `joy1`/`joy2` every cycle (transparent load) and hold `bit_cnt`=0. Clear `overrun`. On synced LOAD high, go to SHIFT.
  - SHIFT: on each synced CLK rising edge, `sr <= {sr[N-2:0],1'b1}` and `bit_cnt++`. When the increment makes `bit_cnt` reach N, pulse `frame_done` and go to DONE.
  - DONE: `JOY_DATA`=1. A further CLK rising edge sets `overrun` and saturates `bit_cnt` at 63.
  - SHIFT or DONE go to LOAD whenever synced LOAD is low.
- LOAD dominates CLK: if a LOAD-low level and a CLK rise are seen in the same cycle, the shift is dropped and the chain reloads.
- CLK edges while LOAD is low are ignored and not counted.

## Timing
- Reset values: `JOY_DATA`=1, `frame_done`=0, `bit_cnt`=0, `overrun`=0, `link_idle`=0, state IDLE, synchronizers all ones.
- After a `JOY_CLK` rise, `JOY_DATA` updates 3 `clk` cycles later (2 sync + 1 register).
- After `JOY_LOAD` falls, `JOY_DATA` reflects the first chain bit 3 cycles later.
- `frame_done` is registered together with the final shift.
- The reader must hold each `JOY_CLK` phase for at least 4 `clk` cycles. Shorter phases are unsupported and may be lost.
- `joy1`/`joy2` are sampled on every LOAD-state cycle, so the last value before LOAD deasserts is the one sent.
- If `reset_n` asserts mid-frame, the block returns to IDLE immediately. The reader sees all-ones (nothing pressed) until the next load.

## Configuration
- `JOY_DB15_RSP_WATCHDOG_EN` defined: a counter increments each cycle and clears on synced LOAD low. `link_idle` goes to 1 when the count reaches `TIMEOUT_CYCLES`, and returns to 0 on the next load. While `link_idle`=1, `JOY_DATA` is forced to 1.
- `JOY_DB15_RSP_WATCHDOG_EN` undefined: there is no counter and `link_idle` is tied to 0.

## Structure
- Shared package `joy_db15_pkg`:
  - state enum `{IDLE, LOAD, SHIFT, DONE}`
  - `JOY_WORD_W`=16
  - constant for the bit layout `FEDCBAUDLR`
- Sub-module `sync_edge` (2-FF synchronizer plus rise detect, reset to 1) is instantiated twice.

## Test plan
- Reset, then idle 20 cycles → `JOY_DATA`=1, `bit_cnt`=0, no `frame_done`.
- `joy1`=16'h0001, `joy2`=16'h0200, load, 32 clocks of period 10 → received stream is all ones except bit 15 (0-based) and bit 22, which are 0. `frame_done` pulses once after the 32nd edge.
- After a completed frame, 3 extra clock edges → `overrun`=1, `bit_cnt`=35, `JOY_DATA`=1. Next load clears `overrun`.
- LOAD low for 5 cycles with a coincident CLK rise → `bit_cnt`=0, first bit equals `~joy1[15]`.
- `reset_n` low after 10 shifts → all outputs take reset values immediately. Next frame shifts correctly from bit 0.
- With `JOY_DB15_RSP_WATCHDOG_EN` and `TIMEOUT_CYCLES`=100, no LOAD for 100 cycles → `link_idle`=1 and `JOY_DATA`=1. A load clears `link_idle`.
